// File: rtl/frame_generator_pkg.sv
// rtl/frame_generator_pkg.sv - register map, reset values and FSM state type for the frame generator
package frame_generator_pkg;

    localparam logic [7:0] ADDR_CTRL    = 8'd0;
    localparam logic [7:0] ADDR_LEN_LO  = 8'd1;
    localparam logic [7:0] ADDR_LEN_HI  = 8'd2;
    localparam logic [7:0] ADDR_GAP     = 8'd3;
    localparam logic [7:0] ADDR_COUNT   = 8'd4;
    localparam logic [7:0] ADDR_SEED_LO = 8'd5;
    localparam logic [7:0] ADDR_SEED_HI = 8'd6;
    localparam logic [7:0] ADDR_STATUS  = 8'd7;
    localparam logic [7:0] ADDR_CSUM0   = 8'd8;
    localparam logic [7:0] ADDR_CSUM1   = 8'd9;
    localparam logic [7:0] ADDR_CSUM2   = 8'd10;
    localparam logic [7:0] ADDR_CSUM3   = 8'd11;
    localparam logic [7:0] ADDR_SENT    = 8'd12;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ABORT_BIT = 1;

    localparam logic [15:0] LEN_RESET   = 16'h0040;
    localparam logic [7:0]  GAP_RESET   = 8'h00;
    localparam logic [7:0]  COUNT_RESET = 8'h01;
    localparam logic [15:0] SEED_RESET  = 16'h0000;

    localparam int STUBBING_FUNCTIONAL  = 0;
    localparam int STUBBING_PASSTHROUGH = 1;

    typedef enum logic [1:0] {
        FG_IDLE,
        FG_SEND,
        FG_GAP
    } fg_state_t;

    typedef struct packed {
        logic [15:0] len;
        logic [7:0]  gap;
        logic [7:0]  count;
        logic [15:0] seed;
    } fg_cfg_t;

    function automatic logic [7:0] csum_byte(input logic [31:0] csum, input logic [1:0] idx);
        return csum[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/frame_generator_if.sv
// rtl/frame_generator_if.sv - register bus and egress stream bundle for the frame generator
interface frame_generator_if;
    logic [7:0]  writedata;
    logic        write;
    logic        chipselect;
    logic [7:0]  address;
    logic        read;
    logic [7:0]  readdata;
    logic [15:0] egress_port_tdata;
    logic        egress_port_tvalid;
    logic        egress_port_tready;
    logic        egress_port_tlast;

    modport master (
        input  writedata, write, chipselect, address, read, egress_port_tready,
        output readdata, egress_port_tdata, egress_port_tvalid, egress_port_tlast
    );

    modport slave (
        output writedata, write, chipselect, address, read, egress_port_tready,
        input  readdata, egress_port_tdata, egress_port_tvalid, egress_port_tlast
    );
endinterface

// File: rtl/frame_generator_csr.sv
// rtl/frame_generator_csr.sv - configuration/status register file with START/ABORT strobes
module frame_generator_csr
    import frame_generator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_chipselect,
    input  logic        i_write,
    input  logic        i_read,
    input  logic [7:0]  i_address,
    input  logic [7:0]  i_writedata,
    output logic [7:0]  o_readdata,
    input  logic        i_busy,
    input  logic        i_done,
    input  logic [31:0] i_checksum,
    input  logic [7:0]  i_sent,
    output fg_cfg_t     o_cfg,
    output logic        o_start,
    output logic        o_abort
);

    fg_cfg_t    r_cfg;
    logic [7:0] r_readdata;
    logic [7:0] w_rdata;
    logic       w_wr;
    logic       w_rd;

    assign w_wr = i_chipselect & i_write;
    assign w_rd = i_chipselect & i_read;

    // Strobes are combinational so the FSM reacts on the same edge that samples the write.
    assign o_start = w_wr && (i_address == ADDR_CTRL) && i_writedata[CTRL_START_BIT];
    assign o_abort = w_wr && (i_address == ADDR_CTRL) && i_writedata[CTRL_ABORT_BIT];

    always_comb begin
        w_rdata = 8'h00;
        case (i_address)
            ADDR_LEN_LO:  w_rdata = r_cfg.len[7:0];
            ADDR_LEN_HI:  w_rdata = r_cfg.len[15:8];
            ADDR_GAP:     w_rdata = r_cfg.gap;
            ADDR_COUNT:   w_rdata = r_cfg.count;
            ADDR_SEED_LO: w_rdata = r_cfg.seed[7:0];
            ADDR_SEED_HI: w_rdata = r_cfg.seed[15:8];
            ADDR_STATUS:  w_rdata = {6'b0, i_done, i_busy};
            ADDR_CSUM0:   w_rdata = csum_byte(i_checksum, 2'd0);
            ADDR_CSUM1:   w_rdata = csum_byte(i_checksum, 2'd1);
            ADDR_CSUM2:   w_rdata = csum_byte(i_checksum, 2'd2);
            ADDR_CSUM3:   w_rdata = csum_byte(i_checksum, 2'd3);
            ADDR_SENT:    w_rdata = i_sent;
            default:      w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg.len   <= LEN_RESET;
            r_cfg.gap   <= GAP_RESET;
            r_cfg.count <= COUNT_RESET;
            r_cfg.seed  <= SEED_RESET;
            r_readdata  <= 8'h00;
        end else begin
            if (w_wr) begin
                case (i_address)
                    ADDR_LEN_LO:  r_cfg.len[7:0]   <= i_writedata;
                    ADDR_LEN_HI:  r_cfg.len[15:8]  <= i_writedata;
                    ADDR_GAP:     r_cfg.gap        <= i_writedata;
                    ADDR_COUNT:   r_cfg.count      <= i_writedata;
                    ADDR_SEED_LO: r_cfg.seed[7:0]  <= i_writedata;
                    ADDR_SEED_HI: r_cfg.seed[15:8] <= i_writedata;
                    default:      ;
                endcase
            end
            if (w_rd) begin
                r_readdata <= w_rdata;
            end
        end
    end

    assign o_cfg      = r_cfg;
    assign o_readdata = r_readdata;

endmodule

// File: rtl/frame_generator.sv
// rtl/frame_generator.sv - programmable stream frame source with running payload checksum
module frame_generator
    import frame_generator_pkg::*;
#(
    parameter int STUBBING = STUBBING_FUNCTIONAL
) (
    input  logic               clk,
    input  logic               reset,
    frame_generator_if.master  bus
);

    fg_cfg_t     w_cfg;
    logic        w_start;
    logic        w_abort;
    logic        w_busy;
    logic        w_start_ok;
    logic        w_abort_req;
    logic        w_abort_any;
    logic        w_more;
    logic        w_beat;
    logic        w_tvalid_out;
    logic [15:0] w_len_m1;

    fg_state_t   r_state;
    fg_cfg_t     r_work;
    logic [15:0] r_word_cnt;
    logic [7:0]  r_gap_cnt;
    logic [15:0] r_tdata;
    logic        r_tvalid;
    logic        r_tlast;
    logic [31:0] r_checksum;
    logic [7:0]  r_sent;
    logic        r_done;
    logic        r_abort_pend;

    frame_generator_csr u_csr (
        .clk          (clk),
        .reset        (reset),
        .i_chipselect (bus.chipselect),
        .i_write      (bus.write),
        .i_read       (bus.read),
        .i_address    (bus.address),
        .i_writedata  (bus.writedata),
        .o_readdata   (bus.readdata),
        .i_busy       (w_busy),
        .i_done       (r_done),
        .i_checksum   (r_checksum),
        .i_sent       (r_sent),
        .o_cfg        (w_cfg),
        .o_start      (w_start),
        .o_abort      (w_abort)
    );

    assign w_busy       = (r_state != FG_IDLE);
    assign w_start_ok   = w_start && !w_busy && (w_cfg.len != 16'd0);
    // A write carrying both START and ABORT is treated as a plain START.
    assign w_abort_req  = w_abort && !w_start;
    assign w_abort_any  = r_abort_pend || w_abort_req;
    assign w_more       = (r_work.count == 8'd0) || ((r_sent + 8'd1) != r_work.count);
    assign w_len_m1     = r_work.len - 16'd1;
    assign w_tvalid_out = (STUBBING == STUBBING_PASSTHROUGH) ? 1'b0 : r_tvalid;
    assign w_beat       = (r_state == FG_SEND) && w_tvalid_out && bus.egress_port_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= FG_IDLE;
            r_work       <= '0;
            r_word_cnt   <= 16'd0;
            r_gap_cnt    <= 8'd0;
            r_tdata      <= 16'd0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_checksum   <= 32'd0;
            r_sent       <= 8'd0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            case (r_state)
                FG_IDLE: begin
                    if (w_start_ok) begin
                        r_state      <= FG_SEND;
                        r_work       <= w_cfg;
                        r_word_cnt   <= 16'd0;
                        r_tdata      <= w_cfg.seed;
                        r_tvalid     <= 1'b1;
                        r_tlast      <= (w_cfg.len == 16'd1);
                        r_checksum   <= 32'd0;
                        r_sent       <= 8'd0;
                        r_done       <= 1'b0;
                        r_abort_pend <= 1'b0;
                    end
                end
                FG_SEND: begin
                    if (w_abort_req) begin
                        r_abort_pend <= 1'b1;
                    end
                    if (w_beat) begin
                        r_checksum <= r_checksum + {16'd0, r_tdata};
                        r_tdata    <= r_tdata + 16'd1;
                        if (r_tlast) begin
                            r_sent     <= r_sent + 8'd1;
                            r_word_cnt <= 16'd0;
                            r_tlast    <= (r_work.len == 16'd1);
                            if (!w_more || w_abort_any) begin
                                r_state      <= FG_IDLE;
                                r_tvalid     <= 1'b0;
                                r_tlast      <= 1'b0;
                                r_done       <= 1'b1;
                                r_abort_pend <= 1'b0;
                            end else if (r_work.gap != 8'd0) begin
                                r_state   <= FG_GAP;
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= r_work.gap - 8'd1;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + 16'd1;
                            r_tlast    <= ((r_word_cnt + 16'd1) == w_len_m1);
                        end
                    end
                end
                FG_GAP: begin
                    if (w_abort_any) begin
                        r_state      <= FG_IDLE;
                        r_done       <= 1'b1;
                        r_abort_pend <= 1'b0;
                    end else if (r_gap_cnt == 8'd0) begin
                        r_state  <= FG_SEND;
                        r_tvalid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state  <= FG_IDLE;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.egress_port_tdata  = r_tdata;
    assign bus.egress_port_tvalid = w_tvalid_out;
    assign bus.egress_port_tlast  = r_tlast;

endmodule
